// File: rtl/seq_match_window_counter.sv
// Counts detector match pulses over windows of WIN_LEN enabled cycles and
// delivers each window's count through a one-entry valid/ready holding register.
// Optional: define SEQ_MATCH_FIRST_IDX_EN to add out_first, the window position of the first match.
module seq_match_window_counter #(
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       match_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [CNT_W-1:0]           out_count,
  output logic                       overrun,
  input  logic                       clr_overrun
`ifdef SEQ_MATCH_FIRST_IDX_EN
  ,
  output logic [$clog2(WIN_LEN)-1:0] out_first
`endif
);

  localparam int                WPOS_W    = $clog2(WIN_LEN);
  localparam logic [WPOS_W-1:0] WPOS_LAST = WPOS_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state;
  logic [WPOS_W-1:0] wpos;
  logic [CNT_W-1:0]  acc;

  logic              win_end;
  logic              load;
  logic              drop;
  logic [CNT_W-1:0]  final_cnt;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    win_end   = 1'b0;
    load      = 1'b0;
    drop      = 1'b0;
    final_cnt = acc;
    win_end   = en && (wpos == WPOS_LAST);
    if (match_in && (acc != CNT_MAX)) final_cnt = acc + CNT_W'(1);
    // The holding register accepts a new result when empty or being drained this cycle.
    load = win_end && ((state == EMPTY) || out_ready);
    drop = win_end && (state == FULL) && !out_ready;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      wpos      <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      overrun   <= 1'b0;
    end else begin
      if (en) begin
        wpos <= win_end ? '0 : wpos + WPOS_W'(1);
        acc  <= win_end ? '0 : final_cnt;
      end

      case (state)
        EMPTY: begin
          if (load) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_count <= final_cnt;
          end
        end
        FULL: begin
          if (load) begin
            out_count <= final_cnt;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase

      // A drop in the same cycle as a clear must still leave the flag set.
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

`ifdef SEQ_MATCH_FIRST_IDX_EN
  logic              first_seen;
  logic [WPOS_W-1:0] first_idx;
  logic [WPOS_W-1:0] final_first;

  // A window with no matches reports the last position.
  assign final_first = first_seen ? first_idx : WPOS_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      first_seen <= 1'b0;
      first_idx  <= '0;
      out_first  <= '0;
    end else begin
      if (en) begin
        if (win_end) begin
          first_seen <= 1'b0;
        end else if (match_in && !first_seen) begin
          first_seen <= 1'b1;
          first_idx  <= wpos;
        end
      end
      if (load) out_first <= final_first;
    end
  end
`endif

endmodule

// File: tb/tb_seq_match_window_counter.sv
// Randomized and directed bench for seq_match_window_counter against a
// window-level reference model; build with SEQ_MATCH_FIRST_IDX_EN to also check out_first.
module tb_seq_match_window_counter;

  localparam int WIN = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       match_in = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_overrun = 1'b0;

  logic       out_valid, overrun;
  logic [4:0] out_count;
  logic       out_valid2, overrun2;
  logic [1:0] out_count2;
`ifdef SEQ_MATCH_FIRST_IDX_EN
  logic [2:0] out_first, out_first2;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: window progress counted in enabled cycles.
  int         m_en_cycles;
  int         m_cnt;
  int         m_first;
  logic       m_valid;
  logic       m_ovr;
  logic [4:0] m_count;
  logic [1:0] m_count2;
`ifdef SEQ_MATCH_FIRST_IDX_EN
  logic [2:0] m_first_out;
`endif

  seq_match_window_counter #(.WIN_LEN(WIN), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .en(en), .match_in(match_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_count(out_count), .overrun(overrun),
    .clr_overrun(clr_overrun)
`ifdef SEQ_MATCH_FIRST_IDX_EN
    , .out_first(out_first)
`endif
  );

  seq_match_window_counter #(.WIN_LEN(WIN), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .match_in(match_in), .out_ready(out_ready),
    .out_valid(out_valid2), .out_count(out_count2), .overrun(overrun2),
    .clr_overrun(clr_overrun)
`ifdef SEQ_MATCH_FIRST_IDX_EN
    , .out_first(out_first2)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_update();
    int  pos;
    bit  wend;
    bit  drop;
    if (rst) begin
      m_en_cycles = 0; m_cnt = 0; m_first = -1;
      m_valid = 1'b0; m_ovr = 1'b0; m_count = '0; m_count2 = '0;
`ifdef SEQ_MATCH_FIRST_IDX_EN
      m_first_out = '0;
`endif
      return;
    end
    pos  = m_en_cycles % WIN;
    wend = en && (pos == WIN - 1);
    drop = 1'b0;
    if (en && match_in) begin
      m_cnt++;
      if (m_first < 0) m_first = pos;
    end
    if (wend) begin
      if (!m_valid || out_ready) begin
        m_valid  = 1'b1;
        m_count  = 5'(m_cnt > 31 ? 31 : m_cnt);
        m_count2 = 2'(m_cnt > 3 ? 3 : m_cnt);
`ifdef SEQ_MATCH_FIRST_IDX_EN
        m_first_out = 3'(m_first < 0 ? WIN - 1 : m_first);
`endif
      end else begin
        drop = 1'b1;
      end
      m_cnt = 0;
      m_first = -1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (clr_overrun) m_ovr = 1'b0;
    if (en) m_en_cycles++;
  endtask

  // One clock: outputs are inspected 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic e, input logic m, input logic r, input logic c);
    en = e; match_in = m; out_ready = r; clr_overrun = c;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    checks++;
    if ({out_valid, out_count, overrun} !== 7'b0) begin
      errors++;
      $display("FAIL reset: valid=%b count=%0d ovr=%b, required 0/0/0", out_valid, out_count, overrun);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'(i % 2), 1'b0, 1'b0);
      checks++;
      if ({out_valid, out_count, overrun} !== 7'b0) begin
        errors++;
        $display("FAIL idle[%0d]: valid=%b count=%0d ovr=%b, required 0/0/0", i, out_valid, out_count, overrun);
      end
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < WIN; i++) begin
      drive(1, (i == 3 || i == 5), 1, 0);
      checks++;
      if (out_valid !== (i == WIN - 1)) begin
        errors++;
        $display("FAIL basic_valid[%0d]: got %b required %b", i, out_valid, (i == WIN - 1));
      end
    end
    checks++;
    if (out_count !== 5'd2) begin
      errors++;
      $display("FAIL basic_count: got %0d required 2", out_count);
    end
`ifdef SEQ_MATCH_FIRST_IDX_EN
    checks++;
    if (out_first !== 3'd3) begin
      errors++;
      $display("FAIL basic_first: got %0d required 3", out_first);
    end
`endif
    drive(0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < WIN; i++) drive(1, (i == 0), 0, 0);
    checks++;
    if ({out_valid, out_count, overrun} !== {1'b1, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL bp_first_window: valid=%b count=%0d ovr=%b, required 1/1/0", out_valid, out_count, overrun);
    end
    for (int i = 0; i < WIN; i++) begin
      drive(1, (i == 1 || i == 2 || i == WIN - 1), 0, 0);
      checks++;
      if (out_count !== 5'd1 || overrun !== (i == WIN - 1)) begin
        errors++;
        $display("FAIL bp_hold[%0d]: count=%0d ovr=%b, required 1/%b", i, out_count, overrun, (i == WIN - 1));
      end
    end
    checks++;
    if (out_count2 !== 2'd1) begin
      errors++;
      $display("FAIL bp_sat_count: got %0d required 1", out_count2);
    end
`ifdef SEQ_MATCH_FIRST_IDX_EN
    checks++;
    if (out_first !== 3'd0) begin
      errors++;
      $display("FAIL bp_first: got %0d required 0", out_first);
    end
`endif
    drive(0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: valid=%b ovr=%b, required 0/1", out_valid, overrun);
    end
    drive(0, 0, 0, 1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_clear: ovr=%b required 0", overrun);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < WIN; i++) drive(1, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 5'd0) begin
      errors++;
      $display("FAIL sim_empty_window: valid=%b count=%0d, required 1/0", out_valid, out_count);
    end
`ifdef SEQ_MATCH_FIRST_IDX_EN
    checks++;
    if (out_first !== 3'd7) begin
      errors++;
      $display("FAIL sim_empty_first: got %0d required 7", out_first);
    end
`endif
    for (int i = 0; i < WIN; i++)
      drive(1, (i == 2 || i == 3 || i == 4 || i == 6 || i == 7), (i == WIN - 1), 0);
    checks++;
    if ({out_valid, out_count, overrun} !== {1'b1, 5'd5, 1'b0}) begin
      errors++;
      $display("FAIL sim_reload: valid=%b count=%0d ovr=%b, required 1/5/0", out_valid, out_count, overrun);
    end
    checks++;
    if (out_count2 !== 2'd3) begin
      errors++;
      $display("FAIL sim_sat_count: got %0d required 3", out_count2);
    end
`ifdef SEQ_MATCH_FIRST_IDX_EN
    checks++;
    if (out_first !== 3'd2) begin
      errors++;
      $display("FAIL sim_first: got %0d required 2", out_first);
    end
`endif
    drive(0, 0, 1, 0);
  endtask

  task automatic test_saturation_gaps();
    for (int i = 0; i < 2 * WIN; i++) begin
      drive(1'(i % 2 == 0), 1, 0, 0);
      checks++;
      if (out_valid !== (i >= 2 * WIN - 2)) begin
        errors++;
        $display("FAIL gap_valid[%0d]: got %b required %b", i, out_valid, (i >= 2 * WIN - 2));
      end
    end
    checks++;
    if (out_count2 !== 2'd3 || out_count !== 5'd8) begin
      errors++;
      $display("FAIL gap_counts: sat=%0d wide=%0d, required 3/8", out_count2, out_count);
    end
  endtask

  task automatic test_overrun_priority();
    for (int i = 0; i < WIN; i++) drive(1, 0, 0, (i == WIN - 1));
    checks++;
    if (overrun !== 1'b1 || out_count !== 5'd8) begin
      errors++;
      $display("FAIL ovr_set_wins: ovr=%b count=%0d, required 1/8", overrun, out_count);
    end
    drive(0, 0, 0, 1);
    checks++;
    if (overrun !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_clear: ovr=%b valid=%b, required 0/1", overrun, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) drive(1, (i < 4), 0, 0);
    rst = 1'b1;
    drive(1, 1, 0, 0);
    rst = 1'b0;
    checks++;
    if ({out_valid, out_count, overrun} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b count=%0d ovr=%b, required 0/0/0", out_valid, out_count, overrun);
    end
    for (int i = 0; i < WIN; i++) drive(1, (i == 6), 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 5'd1 || out_count2 !== 2'd1) begin
      errors++;
      $display("FAIL mid_window: valid=%b count=%0d sat=%0d, required 1/1/1", out_valid, out_count, out_count2);
    end
`ifdef SEQ_MATCH_FIRST_IDX_EN
    checks++;
    if (out_first !== 3'd6) begin
      errors++;
      $display("FAIL mid_first: got %0d required 6", out_first);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
      checks++;
      if (out_valid !== m_valid || out_count !== m_count || overrun !== m_ovr ||
          out_valid2 !== m_valid || out_count2 !== m_count2 || overrun2 !== m_ovr) begin
        errors++;
        $display("FAIL rand[%0d]: valid=%b count=%0d ovr=%b sat=%0d, required %b/%0d/%b/%0d",
                 i, out_valid, out_count, overrun, out_count2, m_valid, m_count, m_ovr, m_count2);
      end
`ifdef SEQ_MATCH_FIRST_IDX_EN
      checks++;
      if (out_first !== m_first_out || out_first2 !== m_first_out) begin
        errors++;
        $display("FAIL rand_first[%0d]: got %0d/%0d required %0d", i, out_first, out_first2, m_first_out);
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_simultaneous();
    test_saturation_gaps();
    test_overrun_priority();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
